// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage holding the PC, driving icache requests and queueing {pc, inst} for decode
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   icache_addr, icache_req    fetch address/request to icache (address frozen while in MISS)
//   icache_data, icache_valid  instruction and combinational hit flag from icache
//   redirect, redirect_pc      1-cycle restart pulse and target (low two bits dropped)
//   inst, inst_pc, inst_valid  FIFO head for decode (zeros when empty)
//   inst_ready                 decode accepts the head
// Optional: define FETCH_PERF_EN to add perf_fetch_cnt (pushes) and perf_miss_cnt (MISS cycles).
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] icache_addr,
   output logic        icache_req,
   input  logic [31:0] icache_data,
   input  logic        icache_valid,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_miss_cnt
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [1:0] BOOT = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] MISS = 2'd2;
   localparam logic [31:0] RST_PC = RESET_PC & ~32'h3;

   logic [1:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d, miss_pc_q, miss_pc_d, pend_pc_q, pend_pc_d;
   logic          pend_v_q, pend_v_d;
   logic [63:0]   mem_q [FIFO_DEPTH];
   logic [63:0]   mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full, empty, push, pop, flush;
   logic [31:0]   push_pc, tgt;

   assign full  = cnt_q == CW'(FIFO_DEPTH);
   assign empty = cnt_q == '0;
   assign tgt   = redirect_pc & ~32'h3;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      miss_pc_d = miss_pc_q;
      pend_v_d  = pend_v_q;
      pend_pc_d = pend_pc_q;
      push      = 1'b0;
      push_pc   = pc_q;
      flush     = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (redirect) begin
               flush = 1'b1;
               pc_d  = tgt;
            end else if (!full) begin
               if (icache_valid) begin
                  push = 1'b1;
                  pc_d = pc_q + 32'd4;
               end else begin
                  miss_pc_d = pc_q;
                  state_d   = MISS;
               end
            end
         end
         MISS: begin
            // a redirect during a refill is parked until the fill completes; the latest one wins
            if (redirect) begin
               flush     = 1'b1;
               pend_v_d  = 1'b1;
               pend_pc_d = tgt;
            end
            if (icache_valid) begin
               state_d  = RUN;
               pend_v_d = 1'b0;
               if (redirect | pend_v_q)
                  pc_d = redirect ? tgt : pend_pc_q;
               else begin
                  push    = 1'b1;
                  push_pc = miss_pc_q;
                  pc_d    = miss_pc_q + 32'd4;
               end
            end
         end
         default: state_d = BOOT;
      endcase
      // flush wins over a same-cycle pop; push never coincides with flush
      pop   = !empty & inst_ready & !flush;
      wr_d  = flush ? '0 : wr_q + AW'(push);
      rd_d  = flush ? '0 : rd_q + AW'(pop);
      cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
      mem_d = mem_q;
      if (push) mem_d[wr_q] = {push_pc, icache_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= BOOT;
         pc_q      <= RST_PC;
         miss_pc_q <= RST_PC;
         pend_v_q  <= 1'b0;
         pend_pc_q <= RST_PC;
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         mem_q     <= '{default: '0};
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         miss_pc_q <= miss_pc_d;
         pend_v_q  <= pend_v_d;
         pend_pc_q <= pend_pc_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         mem_q     <= mem_d;
      end
   end

   assign icache_addr = (state_q == MISS) ? miss_pc_q : pc_q;
   assign icache_req  = (state_q == RUN) ? !full : (state_q == MISS);
   assign inst_valid  = !empty;
   assign inst        = empty ? 32'h0 : mem_q[rd_q][31:0];
   assign inst_pc     = empty ? 32'h0 : mem_q[rd_q][63:32];

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d, miss_cnt_q, miss_cnt_d;
   always_comb begin
      fetch_cnt_d = fetch_cnt_q + 32'(push);
      miss_cnt_d  = miss_cnt_q + 32'(state_q == MISS);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         miss_cnt_q  <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end
   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_miss_cnt  = miss_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, corner sequences and random traffic against a queue-based fetch model
module tb_fetch_unit;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] icache_addr, icache_data, redirect_pc, inst, inst_pc;
   logic        icache_req, icache_valid, redirect, inst_valid, inst_ready;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_miss_cnt;
`endif

   always #5 clk = ~clk;

   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   assign icache_data = dat(icache_addr);

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .icache_addr(icache_addr), .icache_req(icache_req),
      .icache_data(icache_data), .icache_valid(icache_valid),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
`ifdef FETCH_PERF_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: mode 0 = just out of reset, 1 = fetching, 2 = waiting on a refill
   int          m_mode;
   logic [31:0] m_pc, m_mpc, m_ppc;
   logic        m_pend;
   logic [63:0] m_q[$];

   task automatic m_reset();
      m_mode = 0; m_pc = 0; m_mpc = 0; m_ppc = 0; m_pend = 0;
      m_q.delete();
   endtask

   task automatic m_step();
      logic full, ld;
      logic [31:0] t;
      if (!rst_n) begin
         m_reset();
         return;
      end
      full = m_q.size() == DEPTH;
      t = redirect_pc & ~32'h3;
      ld = 0;
      if (redirect) m_q.delete();
      else if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
         if (redirect) m_pc = t;
         else if (!full) begin
            if (icache_valid) begin
               m_q.push_back({m_pc, dat(m_pc)});
               m_pc += 4;
            end else begin
               m_mpc = m_pc;
               m_mode = 2;
            end
         end
      end else begin
         if (redirect) begin
            m_pend = 1;
            m_ppc = t;
         end
         if (icache_valid) begin
            m_mode = 1;
            if (m_pend) m_pc = m_ppc;
            else begin
               m_q.push_back({m_mpc, dat(m_mpc)});
               m_pc = m_mpc + 4;
            end
            m_pend = 0;
         end
      end
      ld = 1;
   endtask

   task automatic m_check();
      logic [63:0] h;
      h = (m_q.size() > 0) ? m_q[0] : 64'h0;
      chk("addr", icache_addr, (m_mode == 2) ? m_mpc : m_pc);
      chk("req", 32'(icache_req), 32'((m_mode == 1) ? (m_q.size() != DEPTH) : (m_mode == 2)));
      chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
      chk("inst", inst, h[31:0]);
      chk("inst_pc", inst_pc, h[63:32]);
   endtask

   task automatic cyc(input logic v, input logic rdy, input logic re, input logic [31:0] rpc);
      icache_valid = v; inst_ready = rdy; redirect = re; redirect_pc = rpc;
      @(posedge clk);
      m_step();
      @(negedge clk);
      m_check();
   endtask

   task automatic chk_reset_outs();
      chk("rst_addr", icache_addr, 32'h0);
      chk("rst_req", 32'(icache_req), 32'h0);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; icache_valid = 0; inst_ready = 0; redirect = 0; redirect_pc = 0;
      m_reset();
      #1;
      chk_reset_outs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic v, rdy, re;
      logic [31:0] rpc, addr;
      logic req, iv;
      logic [31:0] ipc;
   } vec_t;
   vec_t tbl[15];

   function automatic vec_t mk(input logic v, input logic rdy, input logic re, input logic [31:0] rpc,
                               input logic [31:0] addr, input logic req, input logic iv, input logic [31:0] ipc);
      vec_t r;
      r.v = v; r.rdy = rdy; r.re = re; r.rpc = rpc; r.addr = addr; r.req = req; r.iv = iv; r.ipc = ipc;
      return r;
   endfunction

   initial begin
      tbl[0]  = mk(1, 1, 0, 0,     32'h000, 1, 0, 32'h000);
      tbl[1]  = mk(1, 1, 0, 0,     32'h004, 1, 1, 32'h000);
      tbl[2]  = mk(1, 1, 0, 0,     32'h008, 1, 1, 32'h004);
      tbl[3]  = mk(1, 1, 1, 'hFF,  32'h0FC, 1, 0, 32'h000);
      tbl[4]  = mk(1, 1, 0, 0,     32'h100, 1, 1, 32'h0FC);
      for (int i = 5; i < 10; i++) tbl[i] = mk(0, 1, 0, 0, 32'h100, 1, 0, 32'h000);
      tbl[10] = mk(1, 1, 0, 0,     32'h104, 1, 1, 32'h100);
      tbl[11] = mk(1, 0, 0, 0,     32'h108, 0, 1, 32'h100);
      tbl[12] = mk(1, 0, 0, 0,     32'h108, 0, 1, 32'h100);
      tbl[13] = mk(1, 1, 0, 0,     32'h108, 1, 1, 32'h104);
      tbl[14] = mk(1, 1, 0, 0,     32'h10C, 1, 1, 32'h108);

      do_reset();
      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].v, tbl[i].rdy, tbl[i].re, tbl[i].rpc);
         chk($sformatf("tbl%0d_addr", i), icache_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_req", i), 32'(icache_req), 32'(tbl[i].req));
         chk($sformatf("tbl%0d_iv", i), 32'(inst_valid), 32'(tbl[i].iv));
         chk($sformatf("tbl%0d_ipc", i), inst_pc, tbl[i].ipc);
         chk($sformatf("tbl%0d_inst", i), inst, tbl[i].iv ? dat(tbl[i].ipc) : 32'h0);
      end
`ifdef FETCH_PERF_EN
      chk("perf_miss", perf_miss_cnt, 32'd5);
      chk("perf_fetch", perf_fetch_cnt, 32'd6);
`endif

      // redirect with two entries queued
      cyc(1, 0, 0, 0);
      chk("t4_full_valid", 32'(inst_valid), 32'h1);
      cyc(1, 1, 1, 32'h203);
      chk("t4_flushed", 32'(inst_valid), 32'h0);
      chk("t4_addr", icache_addr, 32'h200);
      cyc(1, 1, 0, 0);
      chk("t4_next_pc", inst_pc, 32'h200);

      // redirect during a miss, fill later
      cyc(0, 1, 1, 32'h100);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 32'h400);
      cyc(0, 1, 0, 0);
      chk("t5a_hold", icache_addr, 32'h100);
      chk("t5a_req", 32'(icache_req), 32'h1);
      cyc(1, 1, 0, 0);
      chk("t5a_drop", 32'(inst_valid), 32'h0);
      chk("t5a_target", icache_addr, 32'h400);
      cyc(1, 1, 0, 0);
      chk("t5a_push", inst_pc, 32'h400);

      // redirect in the same cycle as the fill
      cyc(0, 1, 1, 32'h100);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 1, 1, 32'h400);
      chk("t5b_drop", 32'(inst_valid), 32'h0);
      chk("t5b_target", icache_addr, 32'h400);
      cyc(1, 1, 0, 0);
      chk("t5b_push", inst_pc, 32'h400);

      // PC wrap at the top of the address space
      cyc(1, 1, 1, 32'hFFFF_FFFF);
      cyc(1, 1, 0, 0);
      chk("wrap_top", inst_pc, 32'hFFFF_FFFC);
      cyc(1, 1, 0, 0);
      chk("wrap_zero", inst_pc, 32'h0);
      chk("wrap_addr", icache_addr, 32'h4);

      // reset asserted mid-refill with an entry queued
      cyc(1, 0, 1, 32'h100);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("t6_in_miss", 32'(icache_req), 32'h1);
      chk("t6_queued", 32'(inst_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outs();
      m_reset();
      @(negedge clk);
      do_reset();
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      chk("t6_restart", inst_pc, 32'h0);

      // random traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
             ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom & 32'h0000_0FFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
